// File: rtl/fu_logic_if.sv
// rtl/fu_logic_if.sv - issue/result bundle for the pipelined bitwise logic unit
interface fu_logic_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
);
    logic                  ce;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] data_0;
    logic [DATA_WIDTH-1:0] data_1;
    logic [TAG_WIDTH-1:0]  tag_in;
    logic                  flush;
    logic                  result_ready;
    logic                  ready;
    logic                  idle;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [TAG_WIDTH-1:0]  tag_out;
    logic [3:0]            inflight;

    // Issuer / consumer side
    modport master (
        output ce, op, data_0, data_1, tag_in, flush, result_ready,
        input  ready, idle, done, result, tag_out, inflight
    );

    // Functional unit side
    modport slave (
        input  ce, op, data_0, data_1, tag_in, flush, result_ready,
        output ready, idle, done, result, tag_out, inflight
    );
endinterface

// File: rtl/fu_logic.sv
// rtl/fu_logic.sv - pipelined bitwise logic unit with stall, flush and tag passthrough
module fu_logic #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1,
    parameter int TAG_WIDTH  = 6
) (
    input  logic      clk,
    input  logic      rst,
    fu_logic_if.slave bus
);
    // The result is computed at issue time, so each stage only carries result + tag.
    logic [LATENCY-1:0]    r_valid;
    logic [DATA_WIDTH-1:0] r_data [LATENCY];
    logic [TAG_WIDTH-1:0]  r_tag  [LATENCY];

    logic                  w_done;
    logic                  w_stall;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_res;
    logic [3:0]            w_count;

    assign w_done   = r_valid[LATENCY-1];
    assign w_stall  = w_done & ~bus.result_ready;
    // A flush empties the pipe, so the unit is ready in that cycle even if it was stalled.
    assign bus.ready = bus.flush | ~w_stall;
    assign w_accept  = bus.ce & ~w_stall & ~bus.flush;

    // Bitwise operation selected by op, evaluated on the issue-side operands
    always_comb begin
        w_res = '0;
        case (bus.op)
            3'd0: w_res = bus.data_0 & bus.data_1;
            3'd1: w_res = bus.data_0 | bus.data_1;
            3'd2: w_res = bus.data_0 ^ bus.data_1;
            3'd3: w_res = ~(bus.data_0 | bus.data_1);
            3'd4: w_res = ~(bus.data_0 & bus.data_1);
            3'd5: w_res = ~(bus.data_0 ^ bus.data_1);
            3'd6: w_res = bus.data_0 & ~bus.data_1;
            3'd7: w_res = bus.data_0 | ~bus.data_1;
            default: w_res = '0;
        endcase
    end

    // Population count of valid stages
    always_comb begin
        w_count = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_count = w_count + 4'(r_valid[i]);
        end
    end

    // Pipeline advance: reset/flush kill, stall holds, otherwise shift by one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else if (bus.flush) begin
            r_valid <= '0;
        end else if (!w_stall) begin
            r_valid[0] <= w_accept;
            r_data[0]  <= w_res;
            r_tag[0]   <= bus.tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign bus.done     = w_done;
    assign bus.result   = w_done ? r_data[LATENCY-1] : '0;
    assign bus.tag_out  = w_done ? r_tag[LATENCY-1]  : '0;
    assign bus.inflight = w_count;
    assign bus.idle     = (w_count == 4'd0) & ~bus.ce;
endmodule

// File: tb/tb_fu_logic.sv
// tb/tb_fu_logic.sv - directed self-checking bench for fu_logic at several latencies
module tb_fu_logic;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fu_logic_if #(.DATA_WIDTH(32), .TAG_WIDTH(6)) b1 ();
    fu_logic_if #(.DATA_WIDTH(32), .TAG_WIDTH(6)) b2 ();
    fu_logic_if #(.DATA_WIDTH(32), .TAG_WIDTH(6)) b3 ();
    fu_logic_if #(.DATA_WIDTH(32), .TAG_WIDTH(6)) b4 ();

    fu_logic #(.DATA_WIDTH(32), .LATENCY(1), .TAG_WIDTH(6)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    fu_logic #(.DATA_WIDTH(32), .LATENCY(2), .TAG_WIDTH(6)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    fu_logic #(.DATA_WIDTH(32), .LATENCY(3), .TAG_WIDTH(6)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
    fu_logic #(.DATA_WIDTH(32), .LATENCY(4), .TAG_WIDTH(6)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp36 [8];
    int          j;

    initial begin
        exp36[0] = 32'h0F0F_0000; exp36[1] = 32'hFFFF_0F0F;
        exp36[2] = 32'hF0F0_0F0F; exp36[3] = 32'h0000_F0F0;
        exp36[4] = 32'hF0F0_FFFF; exp36[5] = 32'h0F0F_F0F0;
        exp36[6] = 32'hF0F0_0000; exp36[7] = 32'hFFFF_F0F0;

        b1.ce = 0; b1.op = 0; b1.data_0 = 0; b1.data_1 = 0; b1.tag_in = 0; b1.flush = 0; b1.result_ready = 1;
        b2.ce = 0; b2.op = 0; b2.data_0 = 0; b2.data_1 = 0; b2.tag_in = 0; b2.flush = 0; b2.result_ready = 1;
        b3.ce = 0; b3.op = 0; b3.data_0 = 0; b3.data_1 = 0; b3.tag_in = 0; b3.flush = 0; b3.result_ready = 1;
        b4.ce = 0; b4.op = 0; b4.data_0 = 0; b4.data_1 = 0; b4.tag_in = 0; b4.flush = 0; b4.result_ready = 1;

        // Reset state
        step(); step();
        chk("rst_done",     b1.done,     0);
        chk("rst_result",   b1.result,   0);
        chk("rst_tag",      b1.tag_out,  0);
        chk("rst_inflight", b3.inflight, 0);
        chk("rst_ready",    b3.ready,    1);
        chk("rst_idle",     b4.idle,     1);
        b1.ce = 1; #1;
        chk("rst_idle_ce",  b1.idle,     0);
        b1.ce = 0;
        #2 rst = 0;
        step();

        // Single OR op at latency 1
        b1.ce = 1; b1.op = 3'd1; b1.data_0 = 32'hF0F0_0000; b1.data_1 = 32'h0000_0F0F; b1.tag_in = 6'd5;
        step();
        b1.ce = 0;
        chk("l1_done",     b1.done,     1);
        chk("l1_result",   b1.result,   32'hF0F0_0F0F);
        chk("l1_tag",      b1.tag_out,  5);
        chk("l1_inflight", b1.inflight, 1);
        step();
        chk("l1_done_drop", b1.done,    0);
        chk("l1_res_zero",  b1.result,  0);
        chk("l1_tag_zero",  b1.tag_out, 0);
        chk("l1_idle",      b1.idle,    1);

        // All eight ops back-to-back at latency 3
        b3.data_0 = 32'hFFFF_0000; b3.data_1 = 32'h0F0F_0F0F;
        for (int k = 0; k < 12; k++) begin
            b3.ce = (k < 8); b3.op = 3'(k); b3.tag_in = 6'(k);
            step();
            j = k - 2;
            if (j >= 0 && j < 8) begin
                chk("l3_seq_done",   b3.done,    1);
                chk("l3_seq_result", b3.result,  exp36[j]);
                chk("l3_seq_tag",    b3.tag_out, j);
            end else begin
                chk("l3_seq_idle_done", b3.done, 0);
            end
        end
        b3.ce = 0;

        // Stall with result_ready low at latency 3
        b3.result_ready = 0;
        for (int k = 0; k < 3; k++) begin
            b3.ce = 1; b3.op = 3'd2; b3.data_0 = 32'hA; b3.data_1 = 32'(k); b3.tag_in = 6'(10 + k);
            step();
        end
        for (int s = 0; s < 4; s++) begin
            chk("stall_done",     b3.done,     1);
            chk("stall_result",   b3.result,   32'hA);
            chk("stall_tag",      b3.tag_out,  10);
            chk("stall_ready",    b3.ready,    0);
            chk("stall_inflight", b3.inflight, 3);
            if (s < 3) begin
                b3.ce = 1; b3.op = 3'd7; b3.data_0 = 0; b3.data_1 = 0; b3.tag_in = 6'd63;
                step();
            end
        end
        b3.ce = 0; b3.result_ready = 1;
        step();
        chk("rel_r1",  b3.result,  32'hB);
        chk("rel_t1",  b3.tag_out, 11);
        step();
        chk("rel_r2",  b3.result,  32'h8);
        chk("rel_t2",  b3.tag_out, 12);
        chk("rel_d2",  b3.done,    1);
        step();
        chk("rel_done_end", b3.done,     0);
        chk("rel_inflight", b3.inflight, 0);

        // Flush at latency 4
        b4.ce = 1; b4.op = 3'd0; b4.data_0 = 32'hFFFF_FFFF; b4.data_1 = 32'hFFFF_FFFF; b4.tag_in = 6'd1;
        step();
        b4.tag_in = 6'd2;
        step();
        chk("fl_inflight_pre", b4.inflight, 2);
        b4.flush = 1; b4.tag_in = 6'd3; #1;
        chk("fl_ready", b4.ready, 1);
        step();
        chk("fl_inflight", b4.inflight, 0);
        b4.flush = 0; b4.ce = 0; #1;
        chk("fl_idle", b4.idle, 1);
        for (int s = 0; s < 6; s++) begin
            step();
            chk("fl_no_done", b4.done, 0);
        end
        chk("fl_inflight_end", b4.inflight, 0);

        // Asynchronous reset mid-operation at latency 2
        b2.ce = 1; b2.op = 3'd1; b2.data_0 = 32'h1; b2.data_1 = 32'h2; b2.tag_in = 6'd7;
        step();
        b2.ce = 0;
        chk("ar_inflight_pre", b2.inflight, 1);
        #2 rst = 1; #1;
        chk("ar_inflight", b2.inflight, 0);
        chk("ar_done",     b2.done,     0);
        step();
        #2 rst = 0; #1;
        chk("ar_ready", b2.ready, 1);
        for (int s = 0; s < 4; s++) begin
            step();
            chk("ar_no_done", b2.done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fu_logic.md
FU_LOGIC -- requirements
Module: fu_logic

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter LATENCY, default 1, legal range 1..8: pipeline stages from acceptance to result.
REQ-003 SHALL have parameter TAG_WIDTH, default 6: width of the opaque tag carried with each operation.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ce  input  1  issue strobe; the op is accepted on a rising edge where ce=1, ready=1, flush=0.
REQ-007 op  input  3  operation select, sampled on acceptance.
REQ-008 data_0  input  DATA_WIDTH  operand A.
REQ-009 data_1  input  DATA_WIDTH  operand B.
REQ-010 tag_in  input  TAG_WIDTH  tag, sampled on acceptance.
REQ-011 flush  input  1  synchronous kill of all in-flight ops.
REQ-012 result_ready  input  1  consumer accepts the presented result.
REQ-013 ready  output  1  unit can accept an op this cycle.
REQ-014 idle  output  1  no op in flight and ce=0.
REQ-015 done  output  1  result/tag_out valid.
REQ-016 result  output  DATA_WIDTH  result of the oldest completed op.
REQ-017 tag_out  output  TAG_WIDTH  tag of that op.
REQ-018 inflight  output  4  count of valid stages, 0..LATENCY.

Function
REQ-019 Op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN (A & ~B), 7 ORN (A | ~B), all bitwise across DATA_WIDTH.
REQ-020 SHALL implement LATENCY stages S1..S_LATENCY, each holding a valid bit, op, operands (or result) and tag.
REQ-021 Op accepted at edge N SHALL enter S1 at N and reach S_LATENCY at edge N+LATENCY-1 when no stall occurs; done=1 in the following cycle.
REQ-022 done, result and tag_out SHALL be driven from S_LATENCY; result SHALL be 0 and tag_out 0 when done=0.
REQ-023 Stall = done & ~result_ready; on stall every stage SHALL hold its contents and ready SHALL be 0.
REQ-024 With no stall all stages SHALL advance by one each edge; S1 loads the accepted op, otherwise loads invalid.
REQ-025 Throughput SHALL be one op per cycle while result_ready=1; back-to-back ops SHALL complete in issue order.
REQ-026 ce while ready=0 SHALL be ignored; the op is neither accepted nor buffered.
REQ-027 flush=1 at an edge SHALL clear every valid bit; ce in the same cycle SHALL be ignored; ready SHALL be 1 during a flush cycle.
REQ-028 A result presented with done=1 and result_ready=1 at the same edge as flush SHALL count as consumed.
REQ-029 idle SHALL equal (inflight==0) & ~ce, combinationally.
REQ-030 inflight SHALL be the combinational population count of stage valid bits.
REQ-031 A consumed result (done & result_ready) with no new op arriving at S_LATENCY SHALL drop done to 0 after that edge.

Reset
REQ-032 rst=1 SHALL immediately clear all valid bits and stage data, regardless of clk.
REQ-033 During and after reset, until the first acceptance: done=0, result=0, tag_out=0, inflight=0, ready=1, idle=~ce.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight ops; no done pulse for them SHALL appear after release.

Verification
REQ-035 LATENCY=1, DATA_WIDTH=32: ce with op=1, data_0=0xF0F0_0000, data_1=0x0000_0F0F, tag_in=5, result_ready=1 -> next cycle done=1, result=0xF0F0_0F0F, tag_out=5; done=0 the cycle after.
REQ-036 LATENCY=3: issue ops 0..7 on consecutive cycles with data_0=0xFFFF_0000, data_1=0x0F0F_0F0F, tags 0..7 -> done high for 8 consecutive cycles starting 3 cycles after first issue; results in order 0x0F0F_0000, 0xFFFF_0F0F, 0xF0F0_0F0F, 0x0000_F0F0, 0xF0F0_FFFF, 0x0F0F_F0F0, 0xF0F0_0000, 0xFFFF_F0F0.
REQ-037 LATENCY=3: issue 3 ops, hold result_ready=0 for 4 cycles -> done=1 with first result held stable, ready=0, inflight=3; ce during stall not accepted; release -> 3 results in order on 3 consecutive cycles.
REQ-038 LATENCY=4: issue 2 ops, assert flush with ce=1 two cycles later -> inflight=0, no done ever, flush-cycle op not accepted, idle=1 once ce drops.
REQ-039 LATENCY=2: issue op, assert rst asynchronously between edges one cycle later -> done/inflight 0 immediately; after release ready=1 and no done pulse.
